// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing the 128-bit data-RAM line port between the cache (m0)
// and the UART monitor (m1), one transaction in flight, with a response watchdog.
module dram_port_arbiter #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         m0_rreq,
  input  logic         m1_rreq,
  input  logic         m0_wreq,
  input  logic         m1_wreq,
  input  logic [31:0]  m0_adr,
  input  logic [31:0]  m1_adr,
  input  logic [127:0] m0_wdata,
  input  logic [127:0] m1_wdata,
  input  logic [15:0]  m0_mask,
  input  logic [15:0]  m1_mask,
  output logic         m0_ack,
  output logic         m1_ack,
  output logic         m0_rvalid,
  output logic         m1_rvalid,
  output logic         m0_wdone,
  output logic         m1_wdone,
  output logic [127:0] rdata_out,
  output logic [31:0]  ram_radr,
  output logic [31:0]  ram_wadr,
  output logic         ram_rreq,
  output logic         ram_wen,
  output logic [127:0] ram_wdata,
  output logic [15:0]  ram_mask,
  input  logic [127:0] ram_rdata,
  input  logic         ram_rvalid,
  input  logic         ram_wresp,
  input  logic         err_clr,
  output logic         err_pulse,
  output logic         err_flag,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;

  state_t           state_r, state_s;
  logic             last_grant_r, owner_r;
  logic [TMO_W-1:0] cnt_r;
  logic             m0_req_s, m1_req_s, grant_s, sel_s, grant_rd_s;
  logic             rd_hit_s, wr_hit_s, tmo_s;

  assign m0_req_s   = m0_rreq | m0_wreq;
  assign m1_req_s   = m1_rreq | m1_wreq;
  assign grant_rd_s = sel_s ? m1_rreq : m0_rreq;
  assign rd_hit_s   = (state_r == RD_WAIT) && ram_rvalid;
  assign wr_hit_s   = (state_r == WR_WAIT) && ram_wresp;
  // A response landing in the timeout cycle takes precedence over the abort.
  assign tmo_s      = (state_r != IDLE) && !rd_hit_s && !wr_hit_s &&
                      (cnt_r == TMO_W'(TMO_MAX));

  assign m0_rvalid  = rd_hit_s && !owner_r;
  assign m1_rvalid  = rd_hit_s && owner_r;
  assign m0_wdone   = wr_hit_s && !owner_r;
  assign m1_wdone   = wr_hit_s && owner_r;
  assign rdata_out  = rd_hit_s ? ram_rdata : {128{1'b0}};
  assign err_pulse  = tmo_s;
  assign busy       = (state_r != IDLE);

  // Grant selection: round-robin tie-break against the previous winner.
  always_comb begin
    grant_s = 1'b0;
    sel_s   = 1'b0;
    if (state_r == IDLE) begin
      if (m0_req_s && m1_req_s) begin
        grant_s = 1'b1;
        sel_s   = ~last_grant_r;
      end else if (m0_req_s) begin
        grant_s = 1'b1;
        sel_s   = 1'b0;
      end else if (m1_req_s) begin
        grant_s = 1'b1;
        sel_s   = 1'b1;
      end else begin
        grant_s = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_s = grant_rd_s ? RD_WAIT : WR_WAIT;
        else         state_s = IDLE;
      end
      RD_WAIT: begin
        if (rd_hit_s || tmo_s) state_s = IDLE;
        else                   state_s = RD_WAIT;
      end
      WR_WAIT: begin
        if (wr_hit_s || tmo_s) state_s = IDLE;
        else                   state_s = WR_WAIT;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, ownership and watchdog counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      cnt_r        <= {TMO_W{1'b0}};
      err_flag     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        owner_r      <= sel_s;
        last_grant_r <= sel_s;
        cnt_r        <= TMO_W'(1);
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + TMO_W'(1);
      end
      if (tmo_s)        err_flag <= 1'b1;
      else if (err_clr) err_flag <= 1'b0;
    end
  end

  // RAM-side strobes, acks and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rreq  <= 1'b0;
      ram_wen   <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      ram_radr  <= 32'h0;
      ram_wadr  <= 32'h0;
      ram_wdata <= 128'h0;
      ram_mask  <= 16'h0;
    end else begin
      ram_rreq <= grant_s && grant_rd_s;
      ram_wen  <= grant_s && !grant_rd_s;
      m0_ack   <= grant_s && !sel_s;
      m1_ack   <= grant_s && sel_s;
      if (grant_s && grant_rd_s) begin
        ram_radr <= {(sel_s ? m1_adr[31:4] : m0_adr[31:4]), 4'h0};
      end
      if (grant_s && !grant_rd_s) begin
        ram_wadr  <= {(sel_s ? m1_adr[31:4] : m0_adr[31:4]), 4'h0};
        ram_wdata <= sel_s ? m1_wdata : m0_wdata;
        ram_mask  <= sel_s ? m1_mask : m0_mask;
      end
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: directed scenarios plus randomized rounds
// checked against a round-robin transaction model.
module tb_dram_port_arbiter;
  localparam int TMO = 200;

  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_rreq = 0, m1_rreq = 0, m0_wreq = 0, m1_wreq = 0;
  logic [31:0] m0_adr = 0, m1_adr = 0;
  logic [127:0] m0_wdata = 0, m1_wdata = 0;
  logic [15:0] m0_mask = 0, m1_mask = 0;
  logic m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_wdone, m1_wdone;
  logic [127:0] rdata_out, ram_wdata;
  logic [31:0] ram_radr, ram_wadr;
  logic ram_rreq, ram_wen;
  logic [15:0] ram_mask;
  logic [127:0] ram_rdata = 0;
  logic ram_rvalid = 0, ram_wresp = 0, err_clr = 0;
  logic err_pulse, err_flag, busy;

  int checks = 0, failures = 0;
  int model_last = 1;
  bit model_err = 0;

  dram_port_arbiter #(.TMO_W(8), .TMO_MAX(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rreq(m0_rreq), .m1_rreq(m1_rreq), .m0_wreq(m0_wreq), .m1_wreq(m1_wreq),
    .m0_adr(m0_adr), .m1_adr(m1_adr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_mask(m0_mask), .m1_mask(m1_mask), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_wdone(m0_wdone), .m1_wdone(m1_wdone),
    .rdata_out(rdata_out), .ram_radr(ram_radr), .ram_wadr(ram_wadr),
    .ram_rreq(ram_rreq), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_mask(ram_mask),
    .ram_rdata(ram_rdata), .ram_rvalid(ram_rvalid), .ram_wresp(ram_wresp),
    .err_clr(err_clr), .err_pulse(err_pulse), .err_flag(err_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] all_outs();
    return {m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_wdone, m1_wdone, rdata_out,
            ram_radr, ram_wadr, ram_rreq, ram_wen, ram_wdata, ram_mask,
            err_pulse, err_flag, busy};
  endfunction

  task automatic clear_reqs();
    m0_rreq = 0; m0_wreq = 0; m1_rreq = 0; m1_wreq = 0;
  endtask

  task automatic test_reset();
    ram_rdata = {4{32'hDEADBEEF}};
    #1;
    checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_last = 1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  // One arbitration round; called at posedge+1 while the DUT is idle.
  task automatic run_round(input bit r0, input bit w0, input bit r1, input bit w1, input int lat);
    logic [31:0] a0, a1, ea;
    logic [127:0] d0, d1, ed, rd;
    logic [15:0] k0, k1, ek;
    int win;
    bit is_rd;
    logic [1:0] exp_own;
    a0 = $urandom; a1 = $urandom;
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    k0 = 16'($urandom); k1 = 16'($urandom);
    m0_adr = a0; m1_adr = a1; m0_wdata = d0; m1_wdata = d1; m0_mask = k0; m1_mask = k1;
    m0_rreq = r0; m0_wreq = w0; m1_rreq = r1; m1_wreq = w1;
    if ((r0 | w0) && (r1 | w1)) win = 1 - model_last;
    else win = (r0 | w0) ? 0 : 1;
    is_rd = (win == 0) ? r0 : r1;
    ea = ((win == 0) ? a0 : a1) & 32'hFFFF_FFF0;
    ed = (win == 0) ? d0 : d1;
    ek = (win == 0) ? k0 : k1;
    exp_own = (win == 0) ? 2'b10 : 2'b01;
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack, ram_rreq, ram_wen} !== 4'b0) begin failures++; $display("FAIL grant_quiet got=%b exp=0000", {m0_ack, m1_ack, ram_rreq, ram_wen}); end
    @(negedge clk);
    checks++; if ({m0_ack, m1_ack} !== exp_own) begin failures++; $display("FAIL ack got=%b exp=%b", {m0_ack, m1_ack}, exp_own); end
    checks++; if ({ram_rreq, ram_wen} !== (is_rd ? 2'b10 : 2'b01)) begin failures++; $display("FAIL strobe got=%b exp_rd=%b", {ram_rreq, ram_wen}, is_rd); end
    if (is_rd) begin
      checks++; if (ram_radr !== ea) begin failures++; $display("FAIL radr got=%h exp=%h", ram_radr, ea); end
    end else begin
      checks++; if ({ram_wadr, ram_wdata, ram_mask} !== {ea, ed, ek}) begin failures++; $display("FAIL wfields got=%h/%h/%h exp=%h/%h/%h", ram_wadr, ram_wdata, ram_mask, ea, ed, ek); end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_strobe got=%b exp=1", busy); end
    if (win == 0) begin m0_rreq = 0; m0_wreq = 0; end
    else begin m1_rreq = 0; m1_wreq = 0; end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      checks++; if ({m0_ack, m1_ack, ram_rreq, ram_wen, m0_rvalid, m1_rvalid, m0_wdone, m1_wdone, busy} !== 9'b000000001) begin
        failures++; $display("FAIL wait_quiet got=%b exp=000000001", {m0_ack, m1_ack, ram_rreq, ram_wen, m0_rvalid, m1_rvalid, m0_wdone, m1_wdone, busy}); end
    end
    rd = {$urandom, $urandom, $urandom, $urandom};
    ram_rdata = rd;
    if (is_rd) begin ram_rvalid = 1; ram_wresp = 1'($urandom_range(0, 1)); end
    else begin ram_wresp = 1; ram_rvalid = 1'($urandom_range(0, 1)); end
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== (is_rd ? exp_own : 2'b00)) begin failures++; $display("FAIL rvalid got=%b exp=%b", {m0_rvalid, m1_rvalid}, is_rd ? exp_own : 2'b00); end
    checks++; if ({m0_wdone, m1_wdone} !== (is_rd ? 2'b00 : exp_own)) begin failures++; $display("FAIL wdone got=%b exp=%b", {m0_wdone, m1_wdone}, is_rd ? 2'b00 : exp_own); end
    if (is_rd) begin
      checks++; if (rdata_out !== rd) begin failures++; $display("FAIL rdata got=%h exp=%h", rdata_out, rd); end
    end
    @(posedge clk); #1;
    ram_rvalid = 0; ram_wresp = 0;
    clear_reqs();
    model_last = win;
    checks++; if ({busy, m0_rvalid, m1_rvalid, err_pulse} !== 4'b0) begin failures++; $display("FAIL idle_after got=%b exp=0000", {busy, m0_rvalid, m1_rvalid, err_pulse}); end
  endtask

  task automatic test_single_read();
    m1_adr = 32'h0000_1238; m1_rreq = 1;
    @(negedge clk); @(negedge clk);
    checks++; if ({ram_rreq, m1_ack, m0_ack, ram_radr} !== {3'b110, 32'h0000_1230}) begin failures++; $display("FAIL sr_strobe got=%b%b%b %h exp=110 00001230", ram_rreq, m1_ack, m0_ack, ram_radr); end
    m1_rreq = 0;
    @(negedge clk);
    ram_rdata = {16{8'hA5}}; ram_rvalid = 1; #1;
    checks++; if ({m1_rvalid, m0_rvalid, rdata_out} !== {2'b10, {16{8'hA5}}}) begin failures++; $display("FAIL sr_resp got=%b%b %h exp=10 a5..", m1_rvalid, m0_rvalid, rdata_out); end
    @(posedge clk); #1 ram_rvalid = 0;
    model_last = 1;
  endtask

  task automatic test_single_write();
    m0_adr = 32'h40; m0_wdata = {4{32'h1111_1111}}; m0_mask = 16'hfff0; m0_wreq = 1;
    @(negedge clk); @(negedge clk);
    checks++; if ({ram_wen, m0_ack, ram_wadr, ram_mask, ram_wdata} !== {2'b11, 32'h40, 16'hfff0, {4{32'h1111_1111}}}) begin
      failures++; $display("FAIL sw_strobe got=%b%b %h %h %h", ram_wen, m0_ack, ram_wadr, ram_mask, ram_wdata); end
    m0_wreq = 0;
    @(negedge clk);
    checks++; if (ram_wen !== 1'b0) begin failures++; $display("FAIL sw_one_cycle got=%b exp=0", ram_wen); end
    ram_wresp = 1; #1;
    checks++; if ({m0_wdone, m1_wdone} !== 2'b10) begin failures++; $display("FAIL sw_wdone got=%b exp=10", {m0_wdone, m1_wdone}); end
    @(posedge clk); #1 ram_wresp = 0;
    model_last = 0;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) run_round(1, 0, 1, 0, i);
  endtask

  task automatic test_rw_same_master();
    run_round(1, 1, 0, 0, 1);
    run_round(0, 1, 0, 0, 0);
  endtask

  // Read on m0 with no response; optionally respond in the timeout cycle or pulse err_clr there.
  task automatic test_timeout(input bit resp_at_tmo, input bit clr_at_tmo);
    m0_adr = $urandom; m0_rreq = 1;
    @(negedge clk); @(negedge clk);
    m0_rreq = 0;
    for (int k = 2; k <= TMO; k++) begin
      @(negedge clk);
      if (k < TMO) begin
        checks++; if ({err_pulse, busy} !== 2'b01) begin failures++; $display("FAIL tmo_wait k=%0d got=%b exp=01", k, {err_pulse, busy}); end
      end
    end
    ram_rdata = {4{$urandom}};
    ram_rvalid = resp_at_tmo; err_clr = clr_at_tmo; #1;
    checks++; if ({err_pulse, m0_rvalid, m1_rvalid} !== (resp_at_tmo ? 3'b010 : 3'b100)) begin
      failures++; $display("FAIL tmo_cycle got=%b exp=%b", {err_pulse, m0_rvalid, m1_rvalid}, resp_at_tmo ? 3'b010 : 3'b100); end
    if (!resp_at_tmo) model_err = 1;
    else if (clr_at_tmo) model_err = 0;
    @(posedge clk); #1;
    ram_rvalid = 0; err_clr = 0;
    model_last = 0;
    checks++; if ({busy, err_pulse, err_flag} !== {2'b00, model_err}) begin failures++; $display("FAIL tmo_after got=%b exp=00%b", {busy, err_pulse, err_flag}, model_err); end
    ram_rvalid = 1; #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin failures++; $display("FAIL tmo_late got=%b exp=00", {m0_rvalid, m1_rvalid}); end
    @(posedge clk); #1 ram_rvalid = 0;
  endtask

  task automatic test_err_clr();
    err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    model_err = 0;
    checks++; if (err_flag !== model_err) begin failures++; $display("FAIL err_clr got=%b exp=%b", err_flag, model_err); end
  endtask

  task automatic test_reset_mid();
    m1_wreq = 1; m1_adr = $urandom; m1_wdata = {4{$urandom}}; m1_mask = 16'h1234;
    @(negedge clk); @(negedge clk); @(negedge clk);
    clear_reqs();
    rst_n = 0; #1;
    checks++; if (all_outs() !== '0) begin failures++; $display("FAIL rst_mid got=%h exp=0", all_outs()); end
    ram_wresp = 1; #1;
    checks++; if ({m0_wdone, m1_wdone} !== 2'b00) begin failures++; $display("FAIL rst_late got=%b exp=00", {m0_wdone, m1_wdone}); end
    @(negedge clk);
    rst_n = 1; ram_wresp = 0;
    @(posedge clk); #1;
    model_last = 1; model_err = 0;
    run_round(1, 0, 1, 0, 2);
  endtask

  task automatic test_random();
    bit r0, w0, r1, w1;
    for (int i = 0; i < 40; i++) begin
      {r0, w0, r1, w1} = 4'($urandom_range(1, 15));
      run_round(r0, w0, r1, w1, int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_rw_same_master();
    test_timeout(1'b0, 1'b1);
    test_err_clr();
    test_timeout(1'b1, 1'b0);
    test_timeout(1'b0, 1'b0);
    test_err_clr();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
